// File: rtl/cpu_pkg.sv
// Shared opcode, state and PC-select encodings for the
// multi-cycle CPU sequencer.
package cpu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_ANDI = 4'b1001;
  localparam logic [3:0] OP_ORI  = 4'b1010;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b1101;
  localparam logic [3:0] OP_BNE  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

endpackage

// File: rtl/seq_opclass.sv
// Opcode classifier: maps the 4-bit opcode to the
// instruction classes the sequencer branches on.
module seq_opclass
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output logic       is_jmp,
  output logic       is_br,
  output logic       is_mem,
  output logic       is_load,
  output logic       writes_reg
);

  always_comb begin
    is_jmp     = 1'b0;
    is_br      = 1'b0;
    is_mem     = 1'b0;
    is_load    = 1'b0;
    writes_reg = 1'b0;
    unique case (op)
      OP_JMP: is_jmp = 1'b1;
      OP_BEQ,
      OP_BNE: is_br = 1'b1;
      OP_LW: begin
        is_mem     = 1'b1;
        is_load    = 1'b1;
        writes_reg = 1'b1;
      end
      OP_SW: is_mem = 1'b1;
      OP_HALT: ;
      default: writes_reg = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// handshakes, write strobes, run/step/halt and retire counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int          RETIRE_W = 16,
  parameter logic [3:0]  HALT_OP  = 4'b1111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                step,
  input  logic [3:0]          op,
  input  logic                jump,
  input  logic                branch,
  input  logic                write_mem,
  input  logic                write_reg,
  input  logic                wr_flag,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                ir_load,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                mdr_load,
  output logic                reg_we,
  output logic                flag_we,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                halted,
  output logic [RETIRE_W-1:0] retire_cnt
);

  state_t state, nxt;
  logic   retire;
  logic   is_jmp, is_br, is_mem, is_load, writes_reg;

  // Class comes from the opcode; the raw levels are informational.
  logic unused_lvls;
  assign unused_lvls = jump ^ write_reg;

  seq_opclass u_opclass (
    .op         (op),
    .is_jmp     (is_jmp),
    .is_br      (is_br),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .writes_reg (writes_reg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      retire_cnt <= '0;
    end else begin
      state <= nxt;
      if (retire) retire_cnt <= retire_cnt + 1'b1;
    end
  end

  assign halted = (state == S_IDLE);

  always_comb begin
    nxt      = state;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    mdr_load = 1'b0;
    reg_we   = 1'b0;
    flag_we  = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = PC_SEL_INC;
    unique case (state)
      S_IDLE: begin
        if (run || step) nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        nxt = (op == HALT_OP) ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        if (is_jmp) begin
          pc_en  = 1'b1;
          pc_sel = PC_SEL_JMP;
          retire = 1'b1;
        end else if (is_br) begin
          pc_en  = 1'b1;
          pc_sel = branch ? PC_SEL_BR : PC_SEL_INC;
          retire = 1'b1;
        end else if (is_mem) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = write_mem;
        if (dmem_ack) begin
          if (is_load) begin
            mdr_load = 1'b1;
            nxt      = S_WB;
          end else begin
            pc_en  = 1'b1;
            retire = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_we  = writes_reg;
        flag_we = wr_flag;
        pc_en   = 1'b1;
        retire  = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
    if (retire) nxt = run ? S_FETCH : S_IDLE;
  end

endmodule
